ula_seq: RTL and testbench

- Parametrised, sequential successor to the 4-bit combinational ALU.
- Accepts one operation per start/done handshake on WIDTH-bit operands.
- Add/sub/logic complete in one cycle; multiply and divide run as iterative WIDTH-cycle engines.
- Registers a 2*WIDTH-bit result plus status flags, which are held stable for the display path.

---
 rtl/ula_seq_pkg.sv | 17 +
 rtl/ula_seq_if.sv | 38 +++
 rtl/ula_iter_engine.sv | 49 ++++
 rtl/ula_seq.sv | 128 ++++++++++++
 tb/tb_ula_seq.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/ula_seq_pkg.sv
// ula_seq_pkg: opcode codes, state encodings and default sizes shared by the ula_seq slice.
package ula_seq_pkg;
    localparam int ULA_WIDTH      = 4;
    localparam int ULA_BCD_DIGITS = 3;
    localparam logic [3:0] ULA_ADD  = 4'd0;
    localparam logic [3:0] ULA_SUB  = 4'd1;
    localparam logic [3:0] ULA_MULT = 4'd2;
    localparam logic [3:0] ULA_DIV  = 4'd3;
    localparam logic [3:0] ULA_AND  = 4'd4;
    localparam logic [3:0] ULA_OR   = 4'd5;
    localparam logic [3:0] ULA_XOR  = 4'd6;
    localparam logic [3:0] ULA_NOT  = 4'd7;
    localparam logic [1:0] ULA_S_IDLE = 2'd0;
    localparam logic [1:0] ULA_S_CALC = 2'd1;
    localparam logic [1:0] ULA_S_CONV = 2'd2;
    localparam logic [1:0] ULA_S_FIN  = 2'd3;
endpackage

// File: rtl/ula_seq_if.sv
// ula_seq_if: start/done operation bus of ula_seq; bcd exists only when BCD_OUT_EN is defined.
interface ula_seq_if
    import ula_seq_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
`ifdef BCD_OUT_EN
   ,parameter int BCD_DIGITS = ULA_BCD_DIGITS
`endif
);
    logic               start;
    logic [WIDTH-1:0]   operando1;
    logic [WIDTH-1:0]   operando2;
    logic [3:0]         opcode;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               flag_zero;
    logic               flag_carry;
    logic               flag_div0;
    logic               flag_illegal;
`ifdef BCD_OUT_EN
    logic [4*BCD_DIGITS-1:0] bcd;
`endif
    modport master (
        output start, operando1, operando2, opcode,
        input  busy, done, result, flag_zero, flag_carry, flag_div0, flag_illegal
`ifdef BCD_OUT_EN
       ,input  bcd
`endif
    );
    modport slave (
        input  start, operando1, operando2, opcode,
        output busy, done, result, flag_zero, flag_carry, flag_div0, flag_illegal
`ifdef BCD_OUT_EN
       ,output bcd
`endif
    );
endinterface

// File: rtl/ula_iter_engine.sv
// ula_iter_engine: shared shift-add multiplier and restoring divider, one bit per step,
// finish_o flags the last of WIDTH steps; divide result is {remainder, quotient}.
module ula_iter_engine #(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               finish_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   b_q, div_diff;
    logic [WIDTH:0]     mul_sum, div_rem;
    logic               div_q, div_ge;
    logic [CW-1:0]      cnt_q;
    // Both modes share one {hi, lo} register: lo starts as the multiplier / dividend.
    always_comb begin
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? b_q : {WIDTH{1'b0}})};
        div_rem  = p_q[2*WIDTH-1:WIDTH-1];
        div_ge   = div_rem >= {1'b0, b_q};
        div_diff = div_rem[WIDTH-1:0] - b_q;
        p_d      = div_q ? {(div_ge ? div_diff : div_rem[WIDTH-1:0]), p_q[WIDTH-2:0], div_ge}
                         : {mul_sum, p_q[WIDTH-1:1]};
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            p_q   <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            p_q   <= {{WIDTH{1'b0}}, a_i};
            b_q   <= b_i;
            div_q <= div_i;
            cnt_q <= '0;
        end else if (step_i) begin
            p_q   <= p_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end
    assign finish_o = cnt_q == CW'(WIDTH - 1);
    assign result_o = p_q;
endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ALU with start/done handshake and an iterative MULT/DIV engine.
// Defining BCD_OUT_EN adds a double-dabble CONV stage and the bcd output.
module ula_seq
    import ula_seq_pkg::*;
#(
    parameter int WIDTH = ULA_WIDTH
`ifdef BCD_OUT_EN
   ,parameter int BCD_DIGITS = ULA_BCD_DIGITS
`endif
) (
    input logic      clock,
    input logic      reset,
    ula_seq_if.slave bus
);
    localparam int RW = 2*WIDTH;
`ifdef BCD_OUT_EN
    localparam logic [1:0] S_AFTER_CALC = ULA_S_CONV;
`else
    localparam logic [1:0] S_AFTER_CALC = ULA_S_FIN;
`endif
    logic [1:0]    state_q, state_d;
    logic          accept, eng_fin, conv_last;
    logic          iter_d, iter_q, div0_d, div0_q, ill_d, ill_q, carry_d, carry_q;
    logic          busy_q, done_q, fz_q, fc_q, fd_q, fi_q;
    logic [RW-1:0] a2, b2, sum, diff, alu_d, alu_q, eng_res, fin_val, result_q;
    assign accept = state_q == ULA_S_IDLE && bus.start;
    // Single-cycle results and all flags are settled at acceptance, so operands need no holding.
    always_comb begin
        a2      = {{WIDTH{1'b0}}, bus.operando1};
        b2      = {{WIDTH{1'b0}}, bus.operando2};
        sum     = a2 + b2;
        diff    = a2 - b2;
        div0_d  = bus.opcode == ULA_DIV && bus.operando2 == '0;
        iter_d  = bus.opcode == ULA_MULT || (bus.opcode == ULA_DIV && !div0_d);
        ill_d   = bus.opcode[3];
        carry_d = bus.opcode == ULA_ADD ? sum[WIDTH] :
                  bus.opcode == ULA_SUB ? bus.operando2 > bus.operando1 : 1'b0;
        alu_d   = bus.opcode == ULA_ADD ? sum :
                  bus.opcode == ULA_SUB ? diff :
                  bus.opcode == ULA_AND ? a2 & b2 :
                  bus.opcode == ULA_OR  ? a2 | b2 :
                  bus.opcode == ULA_XOR ? a2 ^ b2 :
                  bus.opcode == ULA_NOT ? {{WIDTH{1'b0}}, ~bus.operando1} :
                  div0_d                ? {bus.operando1, {WIDTH{1'b1}}} : '0;
        state_d = state_q == ULA_S_IDLE ? (bus.start ? ULA_S_CALC : ULA_S_IDLE) :
                  state_q == ULA_S_CALC ? ((!iter_q || eng_fin) ? S_AFTER_CALC : ULA_S_CALC) :
                  state_q == ULA_S_CONV ? (conv_last ? ULA_S_FIN : ULA_S_CONV) : ULA_S_IDLE;
    end
    ula_iter_engine #(.WIDTH(WIDTH)) u_engine (
        .clock    (clock),
        .reset    (reset),
        .load_i   (accept && iter_d),
        .step_i   (state_q == ULA_S_CALC && iter_q),
        .div_i    (bus.opcode == ULA_DIV),
        .a_i      (bus.operando1),
        .b_i      (bus.operando2),
        .finish_o (eng_fin),
        .result_o (eng_res)
    );
    assign fin_val = iter_q ? eng_res : alu_q;
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ULA_S_IDLE;
            {iter_q, div0_q, ill_q, carry_q} <= '0;
            alu_q    <= '0;
            result_q <= '0;
            {busy_q, done_q, fz_q, fc_q, fd_q, fi_q} <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != ULA_S_IDLE;
            done_q  <= state_q == ULA_S_FIN;
            if (accept) begin
                iter_q  <= iter_d;
                div0_q  <= div0_d;
                ill_q   <= ill_d;
                carry_q <= carry_d;
                alu_q   <= alu_d;
            end
            if (state_q == ULA_S_FIN) begin
                result_q <= fin_val;
                fz_q     <= fin_val == '0;
                fc_q     <= carry_q;
                fd_q     <= div0_q;
                fi_q     <= ill_q;
            end
        end
    end
`ifdef BCD_OUT_EN
    localparam int BW = 4*BCD_DIGITS;
    localparam int KW = $clog2(RW);
    logic [BW-1:0] dd_q, dd_adj, bcd_q;
    logic [KW-1:0] k_q;
    logic          conv_bit;
    // fin_val is stable during CONV, so bits are picked MSB-first instead of shifting a copy.
    always_comb begin
        conv_bit = |(fin_val & ({1'b1, {(RW-1){1'b0}}} >> k_q));
        dd_adj   = dd_q;
        for (int i = 0; i < BCD_DIGITS; i++)
            dd_adj[4*i +: 4] = dd_q[4*i +: 4] > 4'd4 ? dd_q[4*i +: 4] + 4'd3 : dd_q[4*i +: 4];
    end
    assign conv_last = k_q == KW'(RW - 1);
    always_ff @(posedge clock) begin
        if (!reset) begin
            dd_q  <= '0;
            k_q   <= '0;
            bcd_q <= '0;
        end else if (state_q == ULA_S_CALC) begin
            dd_q <= '0;
            k_q  <= '0;
        end else if (state_q == ULA_S_CONV) begin
            dd_q <= BW'({dd_adj, conv_bit});
            k_q  <= k_q + KW'(1);
        end else if (state_q == ULA_S_FIN) begin
            bcd_q <= dd_q;
        end
    end
    assign bus.bcd = bcd_q;
`else
    assign conv_last = 1'b1;
`endif
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.flag_zero    = fz_q;
    assign bus.flag_carry   = fc_q;
    assign bus.flag_div0    = fd_q;
    assign bus.flag_illegal = fi_q;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: scoreboard bench for ula_seq (WIDTH=4); also covers the BCD_OUT_EN build.
module tb_ula_seq;
    import ula_seq_pkg::*;
    localparam int W = 4;
`ifdef BCD_OUT_EN
    localparam int CONV_LAT = 2*W;
`else
    localparam int CONV_LAT = 0;
`endif
    typedef struct {
        logic [2*W-1:0] res;
        logic [3:0]     flags;
        int             lat;
        int             acc;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int cyc = 0, checks = 0, errors = 0;
    exp_t q[$];
    logic [2*W-1:0] last_res = '0;
    ula_seq_if #(.WIDTH(W)) bus ();
    ula_seq #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: r = (b == 0) ? ((a << W) | ((1 << W) - 1)) : (((a % b) << W) | (a / b));
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = ~a & ((1 << W) - 1);
            default: r = 0;
        endcase
        e.res   = r[2*W-1:0];
        e.flags = {e.res == 0, (op == 0 && r >= (1 << W)) || (op == 1 && b > a), op == 3 && b == 0, op > 7};
        e.lat   = ((op == 2 || (op == 3 && b != 0)) ? W + 1 : 2) + CONV_LAT;
        e.acc   = 0;
        return e;
    endfunction
    function automatic int bcd_of(input int v);
        int r = 0;
        for (int i = 0; i < 3; i++) begin
            r |= (v % 10) << (4*i);
            v /= 10;
        end
        return r;
    endfunction
    // Scoreboard: every done pops one expectation; between dones the result must hold.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) last_res = '0;
        else if (bus.done) begin
            if (q.size() == 0) chk("spurious_done", bus.done, 1'b0);
            else begin
                e = q.pop_front();
                chk("result", bus.result, e.res);
                chk("flags", {bus.flag_zero, bus.flag_carry, bus.flag_div0, bus.flag_illegal}, e.flags);
                chk("latency", cyc - e.acc, e.lat);
`ifdef BCD_OUT_EN
                chk("bcd", bus.bcd, bcd_of(int'(e.res)));
`endif
                last_res = e.res;
            end
        end else chk("hold", bus.result, last_res);
    end
    task automatic issue(input int op, input int a, input int b);
        exp_t e;
        bus.start     = 1'b1;
        bus.opcode    = op[3:0];
        bus.operando1 = a[W-1:0];
        bus.operando2 = b[W-1:0];
        @(posedge clock);
        @(negedge clock);
        e     = model(op, a, b);
        e.acc = cyc;
        q.push_back(e);
        bus.start     = 1'b0;
        bus.opcode    = 4'($urandom);
        bus.operando1 = W'($urandom);
        bus.operando2 = W'($urandom);
    endtask
    task automatic wait_done();
        int n;
        for (n = 0; n < 80 && !bus.done; n++) @(negedge clock);
        chk("done_seen", n < 80, 1'b1);
    endtask
    initial begin
        bus.start = 1'b0;
        bus.opcode = '0;
        bus.operando1 = '0;
        bus.operando2 = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_result", bus.result, '0);
        chk("rst_flags", {bus.flag_zero, bus.flag_carry, bus.flag_div0, bus.flag_illegal}, 4'b0);
        reset = 1'b1;
        @(negedge clock);
        issue(ULA_ADD, 9, 8);   wait_done();
        issue(ULA_SUB, 3, 5);   wait_done();
        issue(ULA_MULT, 15, 15);
        chk("busy_mult", bus.busy, 1'b1);
        bus.start = 1'b1; bus.opcode = ULA_ADD; bus.operando1 = 4'd1; bus.operando2 = 4'd1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        wait_done();
        issue(ULA_DIV, 13, 4);  wait_done();
        issue(ULA_DIV, 7, 0);   wait_done();
        issue(12, 5, 3);        wait_done();
        issue(ULA_NOT, 10, 0);  wait_done();
        issue(ULA_AND, 12, 10); wait_done();
        issue(ULA_OR, 12, 10);  wait_done();
        issue(ULA_XOR, 12, 10); wait_done();
        issue(ULA_SUB, 6, 6);   wait_done();
        for (int i = 0; i < 24; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            wait_done();
        end
        issue(ULA_MULT, 15, 15);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_result", bus.result, '0);
        chk("abort_flags", {bus.flag_zero, bus.flag_carry, bus.flag_div0, bus.flag_illegal}, 4'b0);
        repeat (12) @(negedge clock);
        issue(ULA_ADD, 1, 1);   wait_done();
        repeat (3) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
